// File: rtl/scene_sequencer.sv
// scene_sequencer: per-frame multi-object scene controller.
// Advances per-object angles on frame start, pulses the camera
// transform, then feeds each enabled object's triangle range in turn.
//
// Ports:
//   clk, rst_n      render clock, async active-low reset
//   frame_start     synchronised frame pulse
//   render_busy     renderer busy; frames are rejected while high
//   obj_enable      per-object enable
//   rot_en          per-object {z,y,x} rotate enables
//   obj_base        per-object first triangle index
//   obj_count       per-object triangle count
//   feed_done       feeder completion pulse
//   cam_valid       camera-transform-valid pulse
//   feed_start      feeder begin pulse
//   feed_base       latched base of current object
//   feed_count      latched count of current object
//   obj_idx         current object index
//   ang_x/y/z       current object's angles for the sincos lookups
//   frame_done      all objects sequenced
//   busy            high outside IDLE
//   dropped_frames  saturating count of rejected frame_start pulses
module scene_sequencer #(
    parameter int N_OBJECTS     = 4,
    parameter int ANGLE_BITS    = 8,
    parameter int TRI_IDX_BITS  = 10,
    parameter int SETTLE_CYCLES = 2,
    parameter int ANG_X_INIT    = 10,
    localparam int IW = (N_OBJECTS > 1) ? $clog2(N_OBJECTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  logic                              render_busy,
    input  logic [N_OBJECTS-1:0]              obj_enable,
    input  logic [3*N_OBJECTS-1:0]            rot_en,
    input  logic [N_OBJECTS*TRI_IDX_BITS-1:0] obj_base,
    input  logic [N_OBJECTS*TRI_IDX_BITS-1:0] obj_count,
    input  logic                              feed_done,
    output logic                              cam_valid,
    output logic                              feed_start,
    output logic [TRI_IDX_BITS-1:0]           feed_base,
    output logic [TRI_IDX_BITS-1:0]           feed_count,
    output logic [IW-1:0]                     obj_idx,
    output logic [ANGLE_BITS-1:0]             ang_x,
    output logic [ANGLE_BITS-1:0]             ang_y,
    output logic [ANGLE_BITS-1:0]             ang_z,
    output logic                              frame_done,
    output logic                              busy,
    output logic [15:0]                       dropped_frames
);

    typedef enum logic [2:0] {
        IDLE,
        CAM,
        OBJ_SEL,
        SETTLE,
        FEED_START,
        FEED_WAIT,
        DONE
    } state_t;

    localparam logic [ANGLE_BITS-1:0] XINIT = ANGLE_BITS'(ANG_X_INIT);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJECTS - 1);

    state_t state;
    state_t state_nx;

    logic [3:0] settle_cnt;

    logic [ANGLE_BITS-1:0] ax [N_OBJECTS];
    logic [ANGLE_BITS-1:0] ay [N_OBJECTS];
    logic [ANGLE_BITS-1:0] az [N_OBJECTS];

    logic accept;
    logic reject;
    logic last;
    logic found;
    logic [TRI_IDX_BITS-1:0] sel_base;
    logic [TRI_IDX_BITS-1:0] sel_count;

    always_comb begin
        accept    = (state == IDLE) && frame_start && !render_busy;
        reject    = frame_start && !accept;
        last      = (obj_idx == LAST_IDX);
        sel_base  = obj_base[obj_idx*TRI_IDX_BITS +: TRI_IDX_BITS];
        sel_count = obj_count[obj_idx*TRI_IDX_BITS +: TRI_IDX_BITS];
        found     = obj_enable[obj_idx] && (sel_count != '0);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nx = CAM;
            end
            CAM: state_nx = OBJ_SEL;
            OBJ_SEL: begin
                if (found)
                    state_nx = SETTLE;
                else if (last)
                    state_nx = DONE;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_nx = FEED_START;
            end
            FEED_START: state_nx = FEED_WAIT;
            FEED_WAIT: begin
                if (feed_done)
                    state_nx = last ? DONE : OBJ_SEL;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Pulse outputs are registered copies of the next state, so each
    // pulse is high for exactly the cycle its state is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_valid  <= 1'b0;
            feed_start <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cam_valid  <= (state_nx == CAM);
            feed_start <= (state_nx == FEED_START);
            frame_done <= (state_nx == DONE);
            busy       <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_idx    <= '0;
            settle_cnt <= '0;
            feed_base  <= '0;
            feed_count <= '0;
            ang_x      <= XINIT;
            ang_y      <= '0;
            ang_z      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept)
                        obj_idx <= '0;
                end
                OBJ_SEL: begin
                    if (found) begin
                        settle_cnt <= '0;
                        feed_base  <= sel_base;
                        feed_count <= sel_count;
                        ang_x      <= ax[obj_idx];
                        ang_y      <= ay[obj_idx];
                        ang_z      <= az[obj_idx];
                    end else if (!last) begin
                        obj_idx <= obj_idx + IW'(1);
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + 4'd1;
                FEED_WAIT: begin
                    if (feed_done && !last)
                        obj_idx <= obj_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Angles advance only on an accepted frame; latched copies feed
    // the outputs so mid-frame updates never reach the lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OBJECTS; i++) begin
                ax[i] <= XINIT;
                ay[i] <= '0;
                az[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_OBJECTS; i++) begin
                if (rot_en[3*i])
                    ax[i] <= ax[i] + ANGLE_BITS'(1);
                if (rot_en[3*i+1])
                    ay[i] <= ay[i] + ANGLE_BITS'(1);
                if (rot_en[3*i+2])
                    az[i] <= az[i] + ANGLE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dropped_frames <= '0;
        else if (reject && (dropped_frames != 16'hFFFF))
            dropped_frames <= dropped_frames + 16'd1;
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed checks of frame sequencing, skipping,
// angle wrap, frame drops and mid-sequence reset.
module tb_scene_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        render_busy;
    logic [3:0]  obj_enable;
    logic [11:0] rot_en;
    logic [39:0] obj_base;
    logic [39:0] obj_count;
    logic        feed_done;
    logic        cam_valid;
    logic        feed_start;
    logic [9:0]  feed_base;
    logic [9:0]  feed_count;
    logic [1:0]  obj_idx;
    logic [7:0]  ang_x;
    logic [7:0]  ang_y;
    logic [7:0]  ang_z;
    logic        frame_done;
    logic        busy;
    logic [15:0] dropped_frames;

    int total = 0;
    int bad = 0;

    logic [7:0] cap_x [4];
    logic [7:0] cap_y [4];
    logic [7:0] cap_z [4];
    logic [9:0] cap_b [4];
    int nfeeds;

    scene_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .render_busy(render_busy),
        .obj_enable(obj_enable),
        .rot_en(rot_en),
        .obj_base(obj_base),
        .obj_count(obj_count),
        .feed_done(feed_done),
        .cam_valid(cam_valid),
        .feed_start(feed_start),
        .feed_base(feed_base),
        .feed_count(feed_count),
        .obj_idx(obj_idx),
        .ang_x(ang_x),
        .ang_y(ang_y),
        .ang_z(ang_z),
        .frame_done(frame_done),
        .busy(busy),
        .dropped_frames(dropped_frames)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        render_busy = 1'b0;
        feed_done   = 1'b0;
        obj_enable  = 4'b0000;
        rot_en      = 12'h000;
        obj_base    = {10'd300, 10'd200, 10'd100, 10'd40};
        obj_count   = {10'd5, 10'd5, 10'd5, 10'd5};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Answers each feed_start with feed_done two samples later and
    // records what the feeder saw per object; ends one cycle past
    // frame_done so the FSM is back in IDLE.
    task automatic serve(input int limit, output bit ok);
        int fd;
        fd = 0;
        ok = 1'b0;
        nfeeds = 0;
        for (int i = 0; i < 4; i++) begin
            cap_x[i] = 8'hEE;
            cap_y[i] = 8'hEE;
            cap_z[i] = 8'hEE;
            cap_b[i] = 10'h3FF;
        end
        for (int c = 0; c < limit && !ok; c++) begin
            @(negedge clk);
            feed_done = 1'b0;
            if (frame_done) begin
                ok = 1'b1;
            end else if (feed_start) begin
                cap_x[obj_idx] = ang_x;
                cap_y[obj_idx] = ang_y;
                cap_z[obj_idx] = ang_z;
                cap_b[obj_idx] = feed_base;
                nfeeds++;
                fd = 2;
            end else if (fd > 0) begin
                fd--;
                if (fd == 0)
                    feed_done = 1'b1;
            end
        end
        if (ok)
            @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        render_busy = 1'b0;
        feed_done = 1'b0;
        obj_enable = 4'b0000;
        rot_en = 12'h000;
        @(negedge clk);
        total++;
        if (ang_x !== 8'd10 || ang_y !== 8'd0 || ang_z !== 8'd0) begin
            bad++;
            $display("FAIL reset_ang got %0d/%0d/%0d want 10/0/0",
                     ang_x, ang_y, ang_z);
        end
        total++;
        if (busy !== 1'b0 || dropped_frames !== 16'd0) begin
            bad++;
            $display("FAIL reset_busy_drop got %b/%0d want 0/0",
                     busy, dropped_frames);
        end
        total++;
        if ({cam_valid, feed_start, frame_done} !== 3'b000 ||
            obj_idx !== 2'd0 || feed_base !== 10'd0 ||
            feed_count !== 10'd0) begin
            bad++;
            $display("FAIL reset_outs got %b%b%b idx=%0d b=%0d c=%0d want 0",
                     cam_valid, feed_start, frame_done, obj_idx,
                     feed_base, feed_count);
        end
    endtask

    task automatic test_first_frame();
        logic [3:0] fs_seen;
        bit ok;
        do_reset();
        obj_enable = 4'b1111;
        start_frame();
        total++;
        if (cam_valid !== 1'b1) begin
            bad++;
            $display("FAIL cam_t1 got %b want 1", cam_valid);
        end
        fs_seen = 4'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                total++;
                if (cam_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL cam_t2 got %b want 0", cam_valid);
                end
            end
            fs_seen[c-1] = feed_start;
        end
        total++;
        if (fs_seen !== 4'b0) begin
            bad++;
            $display("FAIL early_feed got %b want 0000", fs_seen);
        end
        @(negedge clk);
        total++;
        if (feed_start !== 1'b1 || feed_base !== 10'd40 ||
            feed_count !== 10'd5 || obj_idx !== 2'd0) begin
            bad++;
            $display("FAIL feed_t5 got fs=%b b=%0d c=%0d i=%0d want 1/40/5/0",
                     feed_start, feed_base, feed_count, obj_idx);
        end
        @(negedge clk);
        @(negedge clk);
        feed_done = 1'b1;
        serve(200, ok);
        total++;
        if (!ok || nfeeds !== 3 || cap_b[3] !== 10'd300) begin
            bad++;
            $display("FAIL frame_all got ok=%b feeds=%0d b3=%0d want 1/3/300",
                     ok, nfeeds, cap_b[3]);
        end
    endtask

    task automatic test_skip();
        int tf0;
        int tf1;
        int tdone;
        int i0;
        int i1;
        int fd;
        logic busy16;
        logic busy17;
        do_reset();
        obj_enable = 4'b0101;
        tf0 = -1;
        tf1 = -1;
        tdone = -1;
        i0 = -1;
        i1 = -1;
        fd = 0;
        busy16 = 1'bx;
        busy17 = 1'bx;
        start_frame();
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            feed_done = 1'b0;
            if (c == 16)
                busy16 = busy;
            if (c == 17)
                busy17 = busy;
            if (feed_start) begin
                if (tf0 < 0) begin
                    tf0 = c;
                    i0 = int'(obj_idx);
                end else begin
                    tf1 = c;
                    i1 = int'(obj_idx);
                end
                fd = 2;
            end else if (fd > 0) begin
                fd--;
                if (fd == 0)
                    feed_done = 1'b1;
            end
            if (frame_done && tdone < 0)
                tdone = c;
        end
        total++;
        if (tf0 !== 5 || i0 !== 0) begin
            bad++;
            $display("FAIL skip_obj0 got t=%0d i=%0d want 5/0", tf0, i0);
        end
        total++;
        if (tf1 !== 12 || i1 !== 2) begin
            bad++;
            $display("FAIL skip_obj2 got t=%0d i=%0d want 12/2", tf1, i1);
        end
        total++;
        if (tdone !== 16) begin
            bad++;
            $display("FAIL skip_done got t=%0d want 16", tdone);
        end
        total++;
        if (busy16 !== 1'b1 || busy17 !== 1'b0) begin
            bad++;
            $display("FAIL skip_busy got %b%b want 10", busy16, busy17);
        end
    endtask

    task automatic test_no_enable();
        int ncam;
        int nfs;
        int tdone;
        do_reset();
        obj_enable = 4'b0000;
        ncam = 0;
        nfs = 0;
        tdone = -1;
        start_frame();
        if (cam_valid)
            ncam++;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (cam_valid)
                ncam++;
            if (feed_start)
                nfs++;
            if (frame_done && tdone < 0)
                tdone = c;
        end
        total++;
        if (ncam !== 1 || nfs !== 0) begin
            bad++;
            $display("FAIL noen_pulses got cam=%0d fs=%0d want 1/0", ncam, nfs);
        end
        total++;
        if (tdone !== 6) begin
            bad++;
            $display("FAIL noen_done got t=%0d want 6", tdone);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bit all_ok;
        do_reset();
        rot_en = 12'b000_000_000_011;
        obj_enable = 4'b0001;
        start_frame();
        serve(100, ok);
        total++;
        if (!ok || cap_x[0] !== 8'd11 || cap_y[0] !== 8'd1 ||
            cap_z[0] !== 8'd0) begin
            bad++;
            $display("FAIL wrap_first got ok=%b %0d/%0d/%0d want 1 11/1/0",
                     ok, cap_x[0], cap_y[0], cap_z[0]);
        end
        obj_enable = 4'b0000;
        all_ok = 1'b1;
        for (int f = 0; f < 254; f++) begin
            start_frame();
            serve(100, ok);
            all_ok = all_ok & ok;
        end
        obj_enable = 4'b0011;
        start_frame();
        serve(100, ok);
        all_ok = all_ok & ok;
        total++;
        if (!all_ok || cap_x[0] !== 8'd10 || cap_y[0] !== 8'd0 ||
            cap_z[0] !== 8'd0) begin
            bad++;
            $display("FAIL wrap_obj0 got ok=%b %0d/%0d/%0d want 1 10/0/0",
                     all_ok, cap_x[0], cap_y[0], cap_z[0]);
        end
        total++;
        if (cap_x[1] !== 8'd10 || cap_y[1] !== 8'd0 || cap_z[1] !== 8'd0) begin
            bad++;
            $display("FAIL wrap_obj1 got %0d/%0d/%0d want 10/0/0",
                     cap_x[1], cap_y[1], cap_z[1]);
        end
    endtask

    task automatic test_drop();
        bit ok;
        int fsc;
        int tdone;
        logic [7:0] x1;
        do_reset();
        rot_en = 12'b000_000_000_001;
        obj_enable = 4'b0001;
        fsc = -1;
        tdone = -1;
        x1 = 8'hEE;
        start_frame();
        for (int c = 2; c <= 30 && tdone < 0; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            feed_done = 1'b0;
            if (feed_start) begin
                fsc = c;
                x1 = ang_x;
            end
            if (fsc > 0 && c == fsc + 1)
                frame_start = 1'b1;
            if (fsc > 0 && c == fsc + 3)
                feed_done = 1'b1;
            if (frame_done)
                tdone = c;
        end
        @(negedge clk);
        total++;
        if (tdone < 0 || x1 !== 8'd11 || dropped_frames !== 16'd1) begin
            bad++;
            $display("FAIL drop_wait got done=%0d x=%0d drop=%0d want x=11 drop=1",
                     tdone, x1, dropped_frames);
        end
        render_busy = 1'b1;
        start_frame();
        render_busy = 1'b0;
        @(negedge clk);
        total++;
        if (dropped_frames !== 16'd2 || busy !== 1'b0 || cam_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_busy got drop=%0d busy=%b cam=%b want 2/0/0",
                     dropped_frames, busy, cam_valid);
        end
        start_frame();
        serve(100, ok);
        total++;
        if (!ok || nfeeds !== 1 || cap_x[0] !== 8'd12 ||
            dropped_frames !== 16'd2) begin
            bad++;
            $display("FAIL drop_after got ok=%b n=%0d x=%0d drop=%0d want 1/1/12/2",
                     ok, nfeeds, cap_x[0], dropped_frames);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int nfs;
        do_reset();
        rot_en = 12'b000_000_000_001;
        obj_enable = 4'b0001;
        start_frame();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ang_x !== 8'd11 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got x=%0d busy=%b want 11/1", ang_x, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || ang_x !== 8'd10 || obj_idx !== 2'd0 ||
            feed_base !== 10'd0 || feed_count !== 10'd0 ||
            {cam_valid, feed_start, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset got busy=%b x=%0d i=%0d b=%0d c=%0d want 0/10/0/0/0",
                     busy, ang_x, obj_idx, feed_base, feed_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nfs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (feed_start || frame_done)
                nfs++;
        end
        total++;
        if (nfs !== 0) begin
            bad++;
            $display("FAIL post_reset_pulses got %0d want 0", nfs);
        end
        start_frame();
        serve(100, ok);
        total++;
        if (!ok || nfeeds !== 1 || cap_x[0] !== 8'd11 || cap_b[0] !== 10'd40) begin
            bad++;
            $display("FAIL restart got ok=%b n=%0d x=%0d b=%0d want 1/1/11/40",
                     ok, nfeeds, cap_x[0], cap_b[0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_skip();
        test_no_enable();
        test_wrap();
        test_drop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
